// File: rtl/sprite_renderer.sv
// Sprite pixel stage: beam position -> frame-LUT address, palette index -> registered RGB222.
// Optional macro SPRITE_BOUNCE_EN makes the sprite origin bounce around the visible area.
module sprite_renderer #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SPR_X0      = 256,
    parameter int unsigned SPR_Y0      = 176,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned FRAME_DIV   = 6,
    parameter logic [5:0]  BG_RGB      = 6'b000001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [4:0] lut_x,
    output logic [4:0] lut_y,
    output logic [1:0] frame_sel,
    input  logic [2:0] lut_pixel,
    output logic [5:0] rgb,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam int unsigned SPR_SIZE = 32 << SCALE_SHIFT;
    localparam logic [10:0] SIZE11   = 11'(SPR_SIZE);

    logic frame_end;
    assign frame_end = (hpos == '0) && (vpos == 10'(V_ACTIVE));

    logic [9:0] ox, oy;

`ifdef SPRITE_BOUNCE_EN
    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPR_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPR_SIZE);

    logic [9:0] ox_q, ox_d, oy_q, oy_d;
    logic       dirx_q, dirx_d, diry_q, diry_d;

    // An axis that would leave its legal range flips direction and holds for that frame.
    always_comb begin
        ox_d   = ox_q;
        oy_d   = oy_q;
        dirx_d = dirx_q;
        diry_d = diry_q;
        if (frame_end) begin
            if (dirx_q) begin
                if (({1'b0, ox_q} + 11'd1) > X_MAX) dirx_d = 1'b0;
                else                                ox_d   = ox_q + 10'd1;
            end else begin
                if (ox_q == '0) dirx_d = 1'b1;
                else            ox_d   = ox_q - 10'd1;
            end
            if (diry_q) begin
                if (({1'b0, oy_q} + 11'd1) > Y_MAX) diry_d = 1'b0;
                else                                oy_d   = oy_q + 10'd1;
            end else begin
                if (oy_q == '0) diry_d = 1'b1;
                else            oy_d   = oy_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ox_q   <= 10'(SPR_X0);
            oy_q   <= 10'(SPR_Y0);
            dirx_q <= 1'b1;
            diry_q <= 1'b1;
        end else begin
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            dirx_q <= dirx_d;
            diry_q <= diry_d;
        end
    end

    assign ox = ox_q;
    assign oy = oy_q;
`else
    assign ox = 10'(SPR_X0);
    assign oy = 10'(SPR_Y0);
`endif

    logic [5:0] div_q, div_d;
    logic [1:0] fsel_q, fsel_d;

    always_comb begin
        div_d  = div_q;
        fsel_d = fsel_q;
        if (frame_end) begin
            if (div_q == 6'(FRAME_DIV - 1)) begin
                div_d  = '0;
                fsel_d = (fsel_q == 2'(NUM_FRAMES - 1)) ? 2'd0 : fsel_q + 2'd1;
            end else begin
                div_d = div_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            fsel_q <= '0;
        end else begin
            div_q  <= div_d;
            fsel_q <= fsel_d;
        end
    end

    logic [10:0] h11, v11, ox11, oy11, dx, dy;
    logic        in_spr_d;
    logic [4:0]  lx_d, ly_d;

    always_comb begin
        h11  = {1'b0, hpos};
        v11  = {1'b0, vpos};
        ox11 = {1'b0, ox};
        oy11 = {1'b0, oy};
        dx   = h11 - ox11;
        dy   = v11 - oy11;
        in_spr_d = display_on
                 && (h11 >= ox11) && (h11 < ox11 + SIZE11)
                 && (v11 >= oy11) && (v11 < oy11 + SIZE11);
        lx_d = in_spr_d ? 5'(dx >> SCALE_SHIFT) : '0;
        ly_d = in_spr_d ? 5'(dy >> SCALE_SHIFT) : '0;
    end

    logic [4:0] lx_q, ly_q;
    logic       in_spr1_q, disp1_q, hs1_q, vs1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lx_q      <= '0;
            ly_q      <= '0;
            in_spr1_q <= 1'b0;
            disp1_q   <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
        end else begin
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            in_spr1_q <= in_spr_d;
            disp1_q   <= display_on;
            hs1_q     <= hsync_in;
            vs1_q     <= vsync_in;
        end
    end

    function automatic logic [5:0] pal(input logic [2:0] idx);
        case (idx)
            3'd1:    pal = 6'b111111;
            3'd2:    pal = 6'b000000;
            3'd3:    pal = 6'b101010;
            3'd4:    pal = 6'b111001;
            3'd5:    pal = 6'b111000;
            3'd6:    pal = 6'b100100;
            3'd7:    pal = 6'b110110;
            default: pal = BG_RGB;
        endcase
    endfunction

    logic [5:0] rgb_q, rgb_d;
    logic       hs2_q, vs2_q;

    always_comb begin
        if (!disp1_q)                            rgb_d = '0;
        else if (!in_spr1_q || lut_pixel == '0)  rgb_d = BG_RGB;
        else                                     rgb_d = pal(lut_pixel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign lut_x     = lx_q;
    assign lut_y     = ly_q;
    assign frame_sel = fsel_q;
    assign rgb       = rgb_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer with default parameters and a synthetic frame LUT.
module tb_sprite_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic [4:0] lut_x, lut_y;
    logic [1:0] frame_sel;
    logic [2:0] lut_pixel;
    logic [5:0] rgb;
    logic       hsync_out, vsync_out;

    sprite_renderer dut (
        .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .lut_x(lut_x), .lut_y(lut_y),
        .frame_sel(frame_sel), .lut_pixel(lut_pixel), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Synthetic frame LUTs: index depends on column, row and frame.
    function automatic logic [2:0] lut_fn(input int x, input int y, input int f);
        lut_fn = 3'((x + 2 * y + 3 + f) % 8);
    endfunction
    assign lut_pixel = lut_fn(int'(lut_x), int'(lut_y), int'(frame_sel));

    logic [5:0] pal_tab [8];
    initial begin
        pal_tab[0] = 6'b000001; pal_tab[1] = 6'b111111; pal_tab[2] = 6'b000000; pal_tab[3] = 6'b101010;
        pal_tab[4] = 6'b111001; pal_tab[5] = 6'b111000; pal_tab[6] = 6'b100100; pal_tab[7] = 6'b110110;
    end

    int n_cmp = 0, n_bad = 0;
    int events = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_fs();
        model_fs = (events / 6) % 4;
    endfunction

    function automatic logic in_box(input int h, input int v, input logic d);
        in_box = d && h >= 256 && h < 384 && v >= 176 && v < 304;
    endfunction

    function automatic logic [9:0] model_lut(input int h, input int v, input logic d);
        if (in_box(h, v, d)) model_lut = {5'((h - 256) / 4), 5'((v - 176) / 4)};
        else                 model_lut = '0;
    endfunction

    function automatic logic [5:0] model_rgb(input int h, input int v, input logic d);
        logic [2:0] p;
        if (!d) return 6'b000000;
        if (!in_box(h, v, d)) return 6'b000001;
        p = lut_fn((h - 256) / 4, (v - 176) / 4, model_fs());
        return pal_tab[p];
    endfunction

    task automatic drive(input int h, input int v, input logic d, input logic hs, input logic vs);
        hpos = 10'(h); vpos = 10'(v); display_on = d; hsync_in = hs; vsync_in = vs;
    endtask

    task automatic frame_pulse();
        drive(0, 480, 1'b0, 1'b0, 1'b1);
        step();
        events++;
        drive(1, 480, 1'b0, 1'b0, 1'b1);
        step();
    endtask

    typedef struct {
        int h; int v; logic d; logic hs; logic vs;
        logic [4:0] lx; logic [4:0] ly; logic [5:0] rgb;
    } vec_t;

    typedef struct { logic [5:0] rgb; logic hs; logic vs; } exp_t;

    vec_t vecs [8];
    exp_t q [$];

    initial begin
        vecs[0] = '{256, 176, 1'b1, 1'b0, 1'b0,  5'd0,  5'd0, 6'b101010};
        vecs[1] = '{295, 196, 1'b1, 1'b1, 1'b0,  5'd9,  5'd5, 6'b100100};
        vecs[2] = '{384, 176, 1'b1, 1'b0, 1'b1,  5'd0,  5'd0, 6'b000001};
        vecs[3] = '{276, 176, 1'b1, 1'b1, 1'b1,  5'd5,  5'd0, 6'b000001};
        vecs[4] = '{300, 200, 1'b0, 1'b0, 1'b0,  5'd0,  5'd0, 6'b000000};
        vecs[5] = '{255, 176, 1'b1, 1'b1, 1'b0,  5'd0,  5'd0, 6'b000001};
        vecs[6] = '{383, 303, 1'b1, 1'b0, 1'b1, 5'd31, 5'd31, 6'b000001};
        vecs[7] = '{256, 304, 1'b1, 1'b1, 1'b1,  5'd0,  5'd0, 6'b000001};

        rst = 1'b1;
        drive(300, 200, 1'b1, 1'b1, 1'b1);
        step(); step();
        check("reset_outputs", {lut_x, lut_y, frame_sel, rgb, hsync_out, vsync_out}, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].d, vecs[i].hs, vecs[i].vs);
            step();
            check($sformatf("vec%0d_lut_xy", i), {lut_x, lut_y}, {vecs[i].lx, vecs[i].ly});
            step();
            check($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
            check($sformatf("vec%0d_syncs", i), {hsync_out, vsync_out}, {vecs[i].hs, vecs[i].vs});
        end

        // Single-cycle sync pulse must appear exactly two edges later.
        drive(10, 10, 1'b1, 1'b0, 1'b0);
        step(); step(); step();
        drive(10, 10, 1'b1, 1'b1, 1'b1);
        step();
        drive(10, 10, 1'b1, 1'b0, 1'b0);
        check("sync_delay_1", {hsync_out, vsync_out}, 2'b00);
        step();
        check("sync_delay_2", {hsync_out, vsync_out}, 2'b11);
        step();
        check("sync_delay_3", {hsync_out, vsync_out}, 2'b00);

        for (int pass = 0; pass < 2; pass++) begin
            q.delete();
            for (int k = 0; k < 300; k++) begin
                int h, v;
                logic d, hs, vs;
                exp_t e;
                logic [9:0] lxy;
                h  = int'($urandom_range(200, 400));
                v  = int'($urandom_range(150, 330));
                d  = ($urandom_range(0, 9) < 8);
                hs = 1'($urandom);
                vs = 1'($urandom);
                drive(h, v, d, hs, vs);
                e.rgb = model_rgb(h, v, d); e.hs = hs; e.vs = vs;
                lxy = model_lut(h, v, d);
                q.push_back(e);
                step();
                check("rand_lut_xy", {lut_x, lut_y}, lxy);
                if (q.size() == 2) begin
                    e = q.pop_front();
                    check("rand_rgb", rgb, e.rgb);
                    check("rand_syncs", {hsync_out, vsync_out}, {e.hs, e.vs});
                end
            end
            if (pass == 0) begin
                for (int n = 0; n < 24; n++) begin
                    frame_pulse();
                    check($sformatf("frame_sel_after_%0d", events), frame_sel, model_fs());
                end
                // hpos != 0 on the blank line is not a frame event.
                for (int n = 0; n < 8; n++) begin
                    drive(5, 480, 1'b0, 1'b0, 1'b1);
                    step();
                end
                for (int n = 0; n < 7; n++) frame_pulse();
                check("frame_sel_pre_rand", frame_sel, model_fs());
            end
        end

        // Reach div=4, frame_sel=2 from a fresh count, then reset mid-line.
        while ((events % 24) != 16) frame_pulse();
        check("frame_sel_before_rst", frame_sel, 2);
        drive(300, 200, 1'b1, 1'b1, 1'b1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        events = 0;
        check("midline_reset_outputs", {lut_x, lut_y, frame_sel, rgb, hsync_out, vsync_out}, '0);
        for (int n = 0; n < 6; n++) begin
            frame_pulse();
            check($sformatf("post_rst_frame_sel_%0d", events), frame_sel, model_fs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before 2000000");
        $fatal(1);
    end

endmodule
